// File: rtl/ant_buf_pkg.sv
// ant_buf_pkg: shared types and helpers for the antenna IQ symbol buffer write side
package ant_buf_pkg;
  localparam int RE_NUM_DEF = 1584;
  typedef logic [31:0] iq_word_t;
  typedef enum logic [1:0] {IDLE, RUN, PAD} wr_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v == m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ant_sat_counter.sv
// ant_sat_counter: enable-driven counter that sticks at all ones
module ant_sat_counter
  import ant_buf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = en_i ? W'(sat_inc(32'(cnt_q), W)) : cnt_q;
  assign cnt_o = cnt_q;
  // count register, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ant_iq_sym_writer.sv
// ant_iq_sym_writer: packs an sop-framed antenna IQ stream into fixed-length symbol writes
module ant_iq_sym_writer
  import ant_buf_pkg::*;
#(
  parameter int ANT        = 4,
  parameter int RE_NUM     = RE_NUM_DEF,
  parameter int ADDR_WIDTH = 11,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [ANT*32-1:0]          i_tdata,
  input  logic                       i_tvalid,
  input  logic                       i_tsop,
  output logic                       o_tready,
  output logic [ADDR_WIDTH-1:0]      o_iq_addr,
  output logic [ANT*32-1:0][31:0]    o_iq_data,
  output logic                       o_iq_vld,
  output logic                       o_iq_last,
  output logic                       o_ant_sel,
  output logic [ERR_CNT_W-1:0]       o_short_cnt,
  output logic [ERR_CNT_W-1:0]       o_long_cnt,
  output logic [ERR_CNT_W-1:0]       o_orphan_cnt
);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(RE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_CNT = (RE_NUM == 1) ? '0 : ADDR_WIDTH'(1);
  wr_state_t                 state_q;
  logic [ADDR_WIDTH-1:0]     cnt_q, addr_q, cnt_nxt;
  iq_word_t [ANT*32-1:0]     data_q, lane_in;
  logic                      vld_q, last_q, sel_q, long_pend_q, at_last;
  logic                      short_en, long_en, orphan_en, idle_drop;
  // only the first ANT lanes carry antenna data; the rest stay zero
  always_comb begin
    lane_in = '0;
    for (int a = 0; a < ANT; a++) lane_in[a] = i_tdata[a*32+:32];
  end
  // a sop arriving mid-symbol is held back so it can open the next symbol after padding
  assign o_tready  = (state_q != PAD) & ~(state_q == RUN & i_tvalid & i_tsop);
  assign at_last   = cnt_q == LAST;
  assign cnt_nxt   = at_last ? '0 : cnt_q + 1'b1;
  assign idle_drop = state_q == IDLE & i_tvalid & ~i_tsop;
  assign orphan_en = idle_drop & ~long_pend_q;
  assign long_en   = idle_drop & long_pend_q;
  assign short_en  = state_q == RUN & i_tvalid & i_tsop;
  // symbol FSM with registered write-port outputs; the held sop beat emits the first pad word
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      sel_q       <= 1'b0;
      long_pend_q <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      sel_q  <= sel_q ^ last_q;
      case (state_q)
        IDLE: if (i_tvalid && i_tsop) begin
          vld_q       <= 1'b1;
          addr_q      <= '0;
          data_q      <= lane_in;
          last_q      <= RE_NUM == 1;
          cnt_q       <= FIRST_CNT;
          state_q     <= (RE_NUM == 1) ? IDLE : RUN;
          long_pend_q <= RE_NUM == 1;
        end
        RUN: if (i_tvalid) begin
          vld_q       <= 1'b1;
          addr_q      <= cnt_q;
          data_q      <= i_tsop ? '0 : lane_in;
          last_q      <= at_last;
          cnt_q       <= cnt_nxt;
          state_q     <= at_last ? IDLE : (i_tsop ? PAD : RUN);
          long_pend_q <= at_last;
        end
        PAD: begin
          vld_q       <= 1'b1;
          addr_q      <= cnt_q;
          data_q      <= '0;
          last_q      <= at_last;
          cnt_q       <= cnt_nxt;
          state_q     <= at_last ? IDLE : PAD;
          long_pend_q <= at_last;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign o_iq_addr = addr_q;
  assign o_iq_data = data_q;
  assign o_iq_vld  = vld_q;
  assign o_iq_last = last_q;
  assign o_ant_sel = sel_q;
  ant_sat_counter #(.W(ERR_CNT_W)) u_short  (.clk_i(i_clk), .rst_i(i_reset), .en_i(short_en),  .cnt_o(o_short_cnt));
  ant_sat_counter #(.W(ERR_CNT_W)) u_long   (.clk_i(i_clk), .rst_i(i_reset), .en_i(long_en),   .cnt_o(o_long_cnt));
  ant_sat_counter #(.W(ERR_CNT_W)) u_orphan (.clk_i(i_clk), .rst_i(i_reset), .en_i(orphan_en), .cnt_o(o_orphan_cnt));
endmodule

// File: tb/tb_ant_iq_sym_writer.sv
// tb_ant_iq_sym_writer: scenario table plus scoreboard for the symbol write packer
module tb_ant_iq_sym_writer;
  localparam int ANT = 4, RE_NUM = 1584, AW = 11, EW = 16;
  typedef logic [ANT*32-1:0][31:0] vec_t;
  typedef struct {logic [AW-1:0] addr; vec_t data; logic last; logic sel;} exp_t;
  typedef struct {int pre; int len; int sop_a; int sop_b; int e_short; int e_long; int e_orph; int e_stall;} row_t;
  logic clk = 0, rst = 1;
  logic [ANT*32-1:0] tdata = '0;
  logic tvalid = 0, tsop = 0;
  logic tready, vld, last, sel;
  logic [AW-1:0] addr;
  vec_t data;
  logic [EW-1:0] short_cnt, long_cnt, orph_cnt;
  exp_t q[$];
  int total = 0, bad = 0, stall = 0;
  int x_short = 0, x_long = 0, x_orph = 0;
  bit m_act = 0, m_sel = 0;
  int m_cnt = 0;
  row_t rows[5];
  ant_iq_sym_writer #(.ANT(ANT), .RE_NUM(RE_NUM), .ADDR_WIDTH(AW), .ERR_CNT_W(EW)) dut (
    .i_clk(clk), .i_reset(rst), .i_tdata(tdata), .i_tvalid(tvalid), .i_tsop(tsop),
    .o_tready(tready), .o_iq_addr(addr), .o_iq_data(data), .o_iq_vld(vld), .o_iq_last(last),
    .o_ant_sel(sel), .o_short_cnt(short_cnt), .o_long_cnt(long_cnt), .o_orphan_cnt(orph_cnt));
  always #5 clk = ~clk;
  function automatic vec_t lanes(int i);
    vec_t v = '0;
    for (int a = 0; a < ANT; a++) v[a] = 32'(i) ^ (32'(a + 1) << 24);
    return v;
  endfunction
  function automatic logic [ANT*32-1:0] pack(vec_t v);
    logic [ANT*32-1:0] p;
    for (int a = 0; a < ANT; a++) p[a*32+:32] = v[a];
    return p;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic push(int a, vec_t d, bit l);
    exp_t e;
    e.addr = AW'(a);
    e.data = d;
    e.last = l;
    e.sel = m_sel;
    q.push_back(e);
    if (l) m_sel = ~m_sel;
  endtask
  task automatic send(int i, bit sop);
    if (sop && m_act) begin
      for (int k = m_cnt; k < RE_NUM; k++) push(k, '0, k == RE_NUM - 1);
      m_act = 0;
    end
    if (!m_act) begin
      if (sop) begin
        push(0, lanes(i), RE_NUM == 1);
        m_act = RE_NUM != 1;
        m_cnt = 1;
      end
    end else begin
      push(m_cnt, lanes(i), m_cnt == RE_NUM - 1);
      if (m_cnt == RE_NUM - 1) m_act = 0;
      m_cnt++;
    end
    @(negedge clk);
    tvalid = 1;
    tsop = sop;
    tdata = pack(lanes(i));
    for (int n = 0; ; n++) begin
      #1;
      if (tready) break;
      stall++;
      if (n > 2000) begin
        chk("tready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask
  task automatic drain(string nm);
    @(negedge clk);
    tvalid = 0;
    tsop = 0;
    repeat (4) @(negedge clk);
    #1;
    chk({nm, "_drain"}, 64'(q.size()), 0);
    chk({nm, "_short"}, 64'(short_cnt), 64'(x_short));
    chk({nm, "_long"}, 64'(long_cnt), 64'(x_long));
    chk({nm, "_orphan"}, 64'(orph_cnt), 64'(x_orph));
  endtask
  task automatic chk_reset(string nm);
    chk({nm, "_tready"}, 64'(tready), 1);
    chk({nm, "_vld"}, 64'(vld), 0);
    chk({nm, "_last"}, 64'(last), 0);
    chk({nm, "_addr"}, 64'(addr), 0);
    chk({nm, "_sel"}, 64'(sel), 0);
    chk({nm, "_data"}, 64'(data == '0), 1);
    chk({nm, "_cnts"}, 64'({short_cnt, long_cnt, orph_cnt}), 0);
  endtask
  always @(negedge clk)
    if (!rst && vld) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL extra_vld got addr=%0d want none", addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (addr !== e.addr || data !== e.data || last !== e.last || sel !== e.sel) begin
          bad++;
          $display("FAIL beat got addr=%0d last=%b sel=%b d=%h want addr=%0d last=%b sel=%b d=%h",
                   addr, last, sel, data[ANT-1:0], e.addr, e.last, e.sel, e.data[ANT-1:0]);
        end
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rows[0] = '{5, 0, -1, -1, 0, 0, 5, 0};
    rows[1] = '{0, 1584, 0, -1, 0, 0, 0, 0};
    rows[2] = '{0, 3168, 0, 1584, 0, 0, 0, 0};
    rows[3] = '{0, 2584, 0, 1000, 1, 0, 0, 584};
    rows[4] = '{0, 1590, 0, -1, 0, 6, 0, 0};
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst0");
    rst = 0;
    foreach (rows[r]) begin
      stall = 0;
      for (int p = 0; p < rows[r].pre; p++) send(p, 0);
      for (int i = 0; i < rows[r].len; i++) send(i, i == rows[r].sop_a || i == rows[r].sop_b);
      x_short += rows[r].e_short;
      x_long += rows[r].e_long;
      x_orph += rows[r].e_orph;
      drain($sformatf("row%0d", r));
      chk($sformatf("row%0d_stall", r), 64'(stall), 64'(rows[r].e_stall));
    end
    for (int i = 0; i < RE_NUM; i++) send(i, i == 0);
    for (int i = 0; i < 701; i++) send(i + 5000, i == 0);
    @(negedge clk);
    tvalid = 0;
    tsop = 0;
    #1;
    chk("pre_rst_sel", 64'(sel), 64'(m_sel));
    chk("pre_rst_queue", 64'(q.size()), 0);
    #1;
    rst = 1;
    #1;
    chk_reset("rst_mid");
    q.delete();
    m_act = 0;
    m_sel = 0;
    m_cnt = 0;
    x_short = 0;
    x_long = 0;
    x_orph = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst_hold");
    rst = 0;
    for (int i = 0; i < RE_NUM; i++) send(i + 9000, i == 0);
    drain("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
